lfsr_stream: RTL and testbench
==============================

Name: lfsr_stream

Overview:
- Parametrised Fibonacci LFSR pseudo-random source with seed load, burst/free-run control, a per-word step count and a valid/ready output stream.
- Next generation of the fixed 8-bit maximal-length LFSR.
- Feeds test-pattern, dither and noise consumers that apply backpressure.

Parameters:
- WIDTH, 8, LFSR and output word width (3..32).
- TAPS, 8'hB8, feedback mask: bit i set means state[i] is XORed into feedback. Default gives x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
- SEED, 1, reset value, and substitute for any all-zero seed load; must be non-zero.
- STEP, 1, LFSR shifts applied per accepted output word (1..WIDTH).
- CNT_W, 16, width of the burst length counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seed_load  in  1  load seed_in into the state (honoured only in IDLE).
- seed_in  in  WIDTH  seed value.
- start  in  1  begin a burst (honoured only in IDLE).
- burst_len  in  CNT_W  number of words in the burst; 0 means free-run.
- stop  in  1  abort RUN and return to IDLE.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  current LFSR state.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a burst completes (not on stop).

Behaviour:
- Reset (async assert, sync release):
  - state=SEED, FSM=IDLE, remaining=0, free=0.
  - out_valid=0, busy=0, done=0, out_data=SEED.
- Single step: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
  - Advance function = STEP single steps, unrolled combinationally within one cycle.
- out_data is always the registered state; no combinational path from out_ready to out_data.
- FSM state IDLE:
  - out_valid=0, busy=0.
  - seed_load: state <= (seed_in==0) ? SEED : seed_in.
  - start with no seed_load: remaining <= burst_len, free <= (burst_len==0), go to RUN. out_valid rises the next cycle showing the current state, so the first word is the seed.
  - seed_load and start in the same cycle: load wins and start is ignored.
- FSM state RUN:
  - out_valid=1, busy=1. seed_load and start are ignored.
  - Transfer = out_valid && out_ready. On a transfer: state advances, and remaining decrements unless free.
  - If not free and remaining==1 at transfer: go to IDLE. out_valid and busy drop and done=1 for exactly one cycle, all in the next cycle.
  - With out_ready low: state and out_data hold; out_valid stays high.
  - stop: go to IDLE next cycle, no done. A transfer in the same cycle still completes (state advances).
  - stop and the final transfer in the same cycle: done is still pulsed (completion wins).
- Counter and lock-up rules:
  - Counter never wraps; burst_len is sampled only at start.
  - Any state==0 (only reachable with a non-maximal TAPS) is replaced by SEED on the next advance.
- Reset mid-burst: immediate return to reset values and IDLE; the partial burst is discarded.

Test Plan:
- Reset, then start with burst_len=5 and out_ready=1 -> out_data 0x01,0x02,0x04,0x08,0x11 on consecutive cycles with out_valid=1; done pulses once; final state 0x23; busy=0.
- burst_len=4; out_ready low for 3 cycles after the 2nd word -> 0x04 held stable with out_valid=1; sequence resumes 0x04,0x08; exactly 4 transfers, then done.
- In IDLE: seed_load with seed_in=0x00 -> state 0x01. seed_load 0x5A plus start in the same cycle -> state 0x5A, FSM stays IDLE. Next start, burst_len=1 -> single word 0x5A.
- burst_len=0 free-run with out_ready=1 -> 255 distinct non-zero words, word 256 equals 0x01; no done. Then stop -> out_valid=0 next cycle, done never pulsed.
- STEP=8 instance, start burst_len=2 from reset -> words 0x01, 0x1C.
- Assert reset during a burst while out_ready=0 -> out_valid, busy and done all 0 immediately; out_data=0x01. A new start after release begins at 0x01.

Source files
------------

// File: rtl/lfsr_stream_if.sv
// Output word stream of lfsr_stream: valid/ready handshake plus the data word.
// The producer owns valid and data, the consumer owns ready.
interface lfsr_stream_if #(
  parameter int WIDTH = 8
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR word source with seed load, burst / free-run control and a
// valid/ready output stream. STEP single shifts are applied per accepted word.
module lfsr_stream #(
  parameter int          WIDTH = 8,
  parameter logic [31:0] TAPS  = 32'h0000_00B8,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          STEP  = 1,
  parameter int          CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic               stop,
  lfsr_stream_if.master      stream,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH-1:0] L_TAPS = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_SEED = SEED[WIDTH-1:0];

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             r_fsm, w_fsm_next;
  logic [WIDTH-1:0] r_state, w_state_next, w_advanced;
  logic [CNT_W-1:0] r_remaining, w_remaining_next;
  logic             r_free, w_free_next;
  logic             r_done, w_done_next;
  logic             w_xfer, w_last;

  // STEP single shifts unrolled into one combinational cone.
  function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < STEP; i++) begin
      v = {v[WIDTH-2:0], ^(v & L_TAPS)};
    end
    return v;
  endfunction

  // An all-zero state is a lock-up point; the next advance escapes to SEED.
  assign w_advanced = (r_state == '0) ? L_SEED : f_advance(r_state);

  assign w_xfer = (r_fsm == RUN) && stream.out_ready;
  assign w_last = !r_free && (r_remaining == CNT_W'(1));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned; this is what keeps the block free of latches.
    w_fsm_next       = r_fsm;
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_free_next      = r_free;
    w_done_next      = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        if (seed_load) begin
          w_state_next = (seed_in == '0) ? L_SEED : seed_in;
        end else if (start) begin
          w_remaining_next = burst_len;
          w_free_next      = (burst_len == '0);
          w_fsm_next       = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_state_next = w_advanced;
          if (!r_free && r_remaining != '0) begin
            w_remaining_next = r_remaining - CNT_W'(1);
          end
        end
        // Completion takes priority over stop so the final word still reports done.
        if (w_xfer && w_last) begin
          w_fsm_next  = IDLE;
          w_done_next = 1'b1;
        end else if (stop) begin
          w_fsm_next = IDLE;
        end
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm       <= IDLE;
      r_state     <= L_SEED;
      r_remaining <= '0;
      r_free      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_free      <= w_free_next;
      r_done      <= w_done_next;
    end
  end

  assign stream.out_valid = (r_fsm == RUN);
  assign stream.out_data  = r_state;
  assign busy             = (r_fsm == RUN);
  assign done             = r_done;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: a behavioural model checked every cycle plus directed
// scenarios with hand-computed word sequences (default and STEP=8 instances).
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       start = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic       stop = 1'b0;
  logic       busy, done;

  logic       seed_load_b = 1'b0;
  logic [7:0] seed_in_b = 8'h00;
  logic       start_b = 1'b0;
  logic [15:0] burst_len_b = 16'd0;
  logic       stop_b = 1'b0;
  logic       busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_stream_if #(.WIDTH(8)) if_a ();
  lfsr_stream_if #(.WIDTH(8)) if_b ();

  lfsr_stream dut_a (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .burst_len(burst_len), .stop(stop),
    .stream(if_a.master), .busy(busy), .done(done)
  );

  lfsr_stream #(.STEP(8)) dut_b (
    .clk(clk), .reset(reset), .seed_load(seed_load_b), .seed_in(seed_in_b),
    .start(start_b), .burst_len(burst_len_b), .stop(stop_b),
    .stream(if_b.master), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one LFSR move is "double the word and add the parity of the tapped bits", mod 256.
  function automatic logic [7:0] m_adv(input logic [7:0] s, input int steps);
    int v;
    v = int'(s);
    if (v == 0) return 8'h01;
    for (int i = 0; i < steps; i++) begin
      v = (v * 2 + ($countones(v & 'hB8) % 2)) % 256;
    end
    return 8'(v);
  endfunction

  logic       m_run, m_free, m_done;
  logic [7:0] m_state;
  logic [15:0] m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_free <= 1'b0; m_done <= 1'b0; m_state <= 8'h01; m_rem <= 16'd0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (seed_load) m_state <= (seed_in == 8'h00) ? 8'h01 : seed_in;
        else if (start) begin
          m_rem <= burst_len; m_free <= (burst_len == 16'd0); m_run <= 1'b1;
        end
      end else begin
        if (if_a.out_ready) m_state <= m_adv(m_state, 1);
        if (if_a.out_ready && !m_free && m_rem != 16'd0) m_rem <= m_rem - 16'd1;
        if (if_a.out_ready && !m_free && m_rem == 16'd1) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end else if (stop) m_run <= 1'b0;
      end
    end
  end

  // Per-cycle compare of {valid, busy, done, data} against the model.
  always @(negedge clk) begin
    check("model", {21'd0, if_a.out_valid, busy, done, if_a.out_data},
                   {21'd0, m_run, m_run, m_done, m_state});
  end

  // Transfer monitors, sampled after the drivers have settled for the next edge.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int done_cnt = 0;
  int done_cnt_b = 0;
  always @(negedge clk) begin
    #2;
    if (if_a.out_valid && if_a.out_ready) q_a.push_back(if_a.out_data);
    if (if_b.out_valid && if_b.out_ready) q_b.push_back(if_b.out_data);
    if (done) done_cnt++;
    if (done_b) done_cnt_b++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (busy && n < budget);
    check({name, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, q_a.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_a.size(); i++)
      check($sformatf("%s_w%0d", name, i), q_a[i], exp[i]);
  endtask

  initial begin
    int d0, n, bad;
    bit seen[256];

    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b1;
    tick();
    check("reset_state", {if_a.out_valid, busy, done, if_a.out_data}, {3'b000, 8'h01});
    check("reset_state_b", {if_b.out_valid, busy_b, done_b, if_b.out_data}, {3'b000, 8'h01});
    reset = 1'b0;

    // STEP=8 instance: two words, 0x01 then eight shifts later 0x1C.
    tick(); start_b = 1'b1; burst_len_b = 16'd2;
    tick(); start_b = 1'b0;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (busy_b && n < 20);
    check("step8_timeout", {31'd0, busy_b}, 32'd0);
    check("step8_count", q_b.size(), 2);
    if (q_b.size() == 2) begin
      check("step8_w0", q_b[0], 8'h01);
      check("step8_w1", q_b[1], 8'h1C);
    end
    check("step8_done", done_cnt_b, 1);

    // Burst of 5 with the consumer always ready.
    q_a.delete(); d0 = done_cnt;
    tick(); start = 1'b1; burst_len = 16'd5; if_a.out_ready = 1'b1;
    tick(); start = 1'b0;
    wait_idle("burst5", 30);
    check_seq("burst5", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11});
    check("burst5_done", done_cnt - d0, 1);
    check("burst5_final", if_a.out_data, 8'h23);

    // Burst of 4 with three stalled cycles after the second word.
    reset = 1'b1; tick(); reset = 1'b0;
    q_a.delete(); d0 = done_cnt;
    tick(); start = 1'b1; burst_len = 16'd4; if_a.out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); if_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), {if_a.out_valid, if_a.out_data}, {1'b1, 8'h04});
    end
    if_a.out_ready = 1'b1;
    wait_idle("stall", 30);
    check_seq("stall", '{8'h01, 8'h02, 8'h04, 8'h08});
    check("stall_done", done_cnt - d0, 1);

    // Seed handling in IDLE: zero seed substitution, load beats start.
    tick(); seed_load = 1'b1; seed_in = 8'h00;
    tick(); seed_load = 1'b0;
    check("seed_zero", if_a.out_data, 8'h01);
    seed_load = 1'b1; seed_in = 8'h5A; start = 1'b1; burst_len = 16'd3;
    tick(); seed_load = 1'b0; start = 1'b0;
    check("load_wins", {if_a.out_valid, busy, if_a.out_data}, {2'b00, 8'h5A});
    q_a.delete(); d0 = done_cnt;
    start = 1'b1; burst_len = 16'd1;
    tick(); start = 1'b0;
    wait_idle("single", 10);
    check_seq("single", '{8'h5A});
    check("single_done", done_cnt - d0, 1);

    // Free-run: full period of 255, then stop without a done pulse.
    seed_load = 1'b1; seed_in = 8'h00;
    tick(); seed_load = 1'b0;
    q_a.delete(); d0 = done_cnt;
    start = 1'b1; burst_len = 16'd0;
    tick(); start = 1'b0;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (q_a.size() < 256 && n < 400);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("freerun_count_ok", {31'd0, q_a.size() >= 256}, 32'd1);
    if (q_a.size() >= 256) begin
      bad = 0;
      for (int i = 0; i < 255; i++) begin
        if (q_a[i] == 8'h00 || seen[q_a[i]]) bad++;
        seen[q_a[i]] = 1'b1;
      end
      check("freerun_distinct", bad, 0);
      check("freerun_wrap", q_a[255], 8'h01);
    end
    check("stop_idle", {if_a.out_valid, busy}, 2'b00);
    tick();
    check("stop_no_done", done_cnt - d0, 0);

    // Reset while a burst is stalled.
    tick(); start = 1'b1; burst_len = 16'd10; if_a.out_ready = 1'b0;
    tick(); start = 1'b0;
    tick(); reset = 1'b1;
    #1;
    check("async_reset", {if_a.out_valid, busy, done, if_a.out_data}, {3'b000, 8'h01});
    tick(); reset = 1'b0;
    q_a.delete();
    tick(); start = 1'b1; burst_len = 16'd2; if_a.out_ready = 1'b1;
    tick(); start = 1'b0;
    wait_idle("post_reset", 10);
    check_seq("post_reset", '{8'h01, 8'h02});

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
